// File: rtl/tmg_seq_ctrl.sv
// tmg_seq_ctrl: sequencer for the 8-stage window/line-buffer datapath.
// Fills the shift chain, emits each window as NUM_TAPS serial taps through the
// output mux, shifts one new sample per window and recirculates at row wrap.
// Optional build macro: TMG_SEQ_STALL_CNT_EN adds the stall_cnt[15:0] output.
module tmg_seq_ctrl #(
  parameter int unsigned FILL_LEN = 8,
  parameter int unsigned NUM_TAPS = 9,
  parameter int unsigned ROW_W    = 4,
  parameter int unsigned NUM_WIN  = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       out_ready,
  output logic       shift_en,
  output logic       mux_sel_a,
  output logic       mux_sel_b,
  output logic [3:0] out_sel,
  output logic       data_valid,
  output logic [3:0] data_tap,
  output logic       busy,
  output logic       done
`ifdef TMG_SEQ_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam logic [3:0] SEL_HOLD = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_EMIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  fill_cnt;
  logic [CNT_W-1:0]  tap_cnt;
  logic [CNT_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  col_cnt;

  logic capture;
  logic accept;
  logic row_wrap;

  assign row_wrap = (col_cnt == CNT_W'(ROW_W - 1));

  // State decodes; both come straight from the state register
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Same-cycle handshake, shift enable, recirculation and output-mux selects
  always_comb begin
    in_ready  = 1'b0;
    shift_en  = 1'b0;
    mux_sel_a = 1'b0;
    mux_sel_b = 1'b0;
    out_sel   = SEL_HOLD;
    capture   = 1'b0;
    accept    = 1'b0;
    case (state)
      S_FILL: begin
        in_ready = 1'b1;
        shift_en = in_valid;
        accept   = in_valid;
      end
      S_EMIT: begin
        // tap 0 is the live fmap, so it also needs a valid sample
        capture = out_ready && ((tap_cnt != '0) || in_valid);
        if (capture) out_sel = 4'(tap_cnt);
      end
      S_SHIFT: begin
        in_ready  = 1'b1;
        shift_en  = in_valid;
        accept    = in_valid;
        mux_sel_a = row_wrap;
        mux_sel_b = row_wrap;
      end
      default: ;
    endcase
  end

  // Sequencer state, counters and registered tap tagging
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      fill_cnt   <= '0;
      tap_cnt    <= '0;
      win_cnt    <= '0;
      col_cnt    <= '0;
      data_valid <= 1'b0;
      data_tap   <= 4'h0;
    end else begin
      data_valid <= capture;
      if (capture) data_tap <= 4'(tap_cnt);
      case (state)
        S_IDLE: begin
          fill_cnt <= '0;
          tap_cnt  <= '0;
          win_cnt  <= '0;
          col_cnt  <= '0;
          if (start) state <= S_FILL;
        end
        S_FILL: begin
          if (accept) begin
            fill_cnt <= fill_cnt + CNT_W'(1);
            if (fill_cnt == CNT_W'(FILL_LEN - 1)) begin
              tap_cnt <= '0;
              state   <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (capture) begin
            tap_cnt <= tap_cnt + CNT_W'(1);
            if (tap_cnt == CNT_W'(NUM_TAPS - 1)) state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (accept) begin
            win_cnt <= win_cnt + CNT_W'(1);
            col_cnt <= row_wrap ? '0 : col_cnt + CNT_W'(1);
            tap_cnt <= '0;
            if (win_cnt == CNT_W'(NUM_WIN - 1)) state <= S_DONE;
            else                                state <= S_EMIT;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TMG_SEQ_STALL_CNT_EN
  logic stall;
  assign stall = (((state == S_FILL) || (state == S_SHIFT)) && !in_valid) ||
                 ((state == S_EMIT) && !capture);

  // Saturating count of busy cycles that made no progress
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
    end else if ((state == S_IDLE) && start) begin
      stall_cnt <= 16'h0000;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_tmg_seq_ctrl.sv
// Testbench for tmg_seq_ctrl: per-cycle scoreboard driven by an expected
// event script (fill shifts, taps, window shifts, done) built per frame.
module tb_tmg_seq_ctrl;

  localparam int FILL_LEN = 8;
  localparam int NUM_TAPS = 9;
  localparam int ROW_W    = 4;
  localparam int NUM_WIN  = 8;
  localparam int EV_SHIFT = 16;
  localparam int EV_WRAP  = 17;
  localparam int EV_DONE  = 32;
  localparam int BUDGET   = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, shift_en, mux_sel_a, mux_sel_b;
  logic [3:0] out_sel;
  logic       data_valid;
  logic [3:0] data_tap;
  logic       busy, done;
`ifdef TMG_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  tmg_seq_ctrl #(
    .FILL_LEN(FILL_LEN), .NUM_TAPS(NUM_TAPS), .ROW_W(ROW_W),
    .NUM_WIN(NUM_WIN), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .out_ready(out_ready), .shift_en(shift_en),
    .mux_sel_a(mux_sel_a), .mux_sel_b(mux_sel_b), .out_sel(out_sel),
    .data_valid(data_valid), .data_tap(data_tap), .busy(busy), .done(done)
`ifdef TMG_SEQ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected event script: 0..8 = tap k, 16/17 = shift (plain/row wrap), 32 = done
  int q[$];
  bit prev_cap = 1'b0;
  int prev_tap = 0;

  // Observations from the most recent cycle
  logic [3:0] last_os;
  logic       last_sh, last_ms, last_dn, last_bz;
  int         n_shift = 0;
  int         n_done = 0;
  int         wraps[$];
`ifdef TMG_SEQ_STALL_CNT_EN
  logic [15:0] last_stall;
`endif

  task automatic build_frame();
    q.delete();
    for (int i = 0; i < FILL_LEN; i++) q.push_back(EV_SHIFT);
    for (int w = 0; w < NUM_WIN; w++) begin
      for (int k = 0; k < NUM_TAPS; k++) q.push_back(k);
      q.push_back(((w + 1) % ROW_W == 0) ? EV_WRAP : EV_SHIFT);
    end
    q.push_back(EV_DONE);
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    prev_cap = 1'b0;
  endtask

  // One clock of stimulus, compared against the event script
  task automatic cycle(input bit st, input bit iv, input bit ordy);
    int head;
    bit e_ir, e_sh, e_ms, e_cap, e_dn, e_bz;
    logic [3:0]  e_os;
    logic [10:0] e_vec, a_vec;
    start = st; in_valid = iv; out_ready = ordy;
    @(negedge clk);
    head  = (q.size() != 0) ? q[0] : -1;
    e_bz  = (head != -1);
    e_ir  = (head == EV_SHIFT) || (head == EV_WRAP);
    e_sh  = e_ir && iv;
    e_ms  = (head == EV_WRAP);
    e_cap = (head >= 0) && (head < NUM_TAPS) && ordy && ((head != 0) || iv);
    e_os  = e_cap ? 4'(head) : 4'hF;
    e_dn  = (head == EV_DONE);
    e_vec = {e_ir, e_sh, e_ms, e_ms, e_os, e_bz, e_dn, prev_cap};
    a_vec = {in_ready, shift_en, mux_sel_a, mux_sel_b, out_sel, busy, done, data_valid};
    checks++;
    if (a_vec !== e_vec) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t {ir,sh,sa,sb,os,busy,done,dv} got %b want %b",
               $time, a_vec, e_vec);
    end
    if (prev_cap) begin
      checks++;
      if (data_tap !== 4'(prev_tap)) begin
        errors++;
        $display("FAIL data_tap t=%0t got %0d want %0d", $time, data_tap, prev_tap);
      end
    end
    last_os = out_sel; last_sh = shift_en; last_ms = mux_sel_a;
    last_dn = done;    last_bz = busy;
`ifdef TMG_SEQ_STALL_CNT_EN
    last_stall = stall_cnt;
`endif
    if (shift_en) begin
      n_shift++;
      if (mux_sel_a && n_shift > FILL_LEN) wraps.push_back(n_shift - FILL_LEN);
    end
    if (done) n_done++;
    if (e_sh || e_cap || e_dn) void'(q.pop_front());
    prev_cap = e_cap;
    prev_tap = head;
    if (head == -1 && st) build_frame();
    @(posedge clk); #1;
  endtask

  task automatic begin_frame();
    n_shift = 0; n_done = 0; wraps.delete();
    cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_to_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      cycle(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      if (last_dn) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, shift_en, mux_sel_a, mux_sel_b, out_sel, data_valid, data_tap, done, busy}
        !== {4'b0000, 4'hF, 1'b0, 4'h0, 2'b00}) begin
      errors++;
      $display("FAIL reset_values got ir=%b sh=%b sa=%b sb=%b os=%h dv=%b dt=%h dn=%b bz=%b want 0 0 0 0 f 0 0 0 0",
               in_ready, shift_en, mux_sel_a, mux_sel_b, out_sel, data_valid, data_tap, done, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill_emit();
    bit ok;
    begin_frame();
    for (int i = 0; i < FILL_LEN; i++) cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (n_shift != FILL_LEN) begin
      errors++;
      $display("FAIL fill_shift_count got %0d want %0d", n_shift, FILL_LEN);
    end
    for (int k = 0; k < NUM_TAPS; k++) begin
      cycle(1'b0, 1'b1, 1'b1);
      checks++;
      if (last_os !== 4'(k)) begin
        errors++;
        $display("FAIL emit_out_sel got %h want %h", last_os, 4'(k));
      end
    end
    run_to_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fill_emit_timeout got no done want done within %0d cycles", BUDGET);
    end
  endtask

  task automatic test_reset_mid_emit();
    begin_frame();
    for (int i = 0; i < FILL_LEN; i++) cycle(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b1);
    n_done = 0;
    apply_reset();
    cycle(1'b0, 1'b1, 1'b1);
    checks++;
    if ({last_bz, last_os} !== {1'b0, 4'hF}) begin
      errors++;
      $display("FAIL reset_mid_emit got busy=%b out_sel=%h want busy=0 out_sel=f", last_bz, last_os);
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b1);
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL reset_no_done got %0d pulses want 0", n_done);
    end
  endtask

  task automatic test_fill_gap();
    bit ok;
    begin_frame();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (last_sh !== 1'b0) begin
        errors++;
        $display("FAIL fill_gap_shift got %b want 0", last_sh);
      end
    end
    cycle(1'b0, 1'b1, 1'b0);
`ifdef TMG_SEQ_STALL_CNT_EN
    checks++;
    if (last_stall !== 16'd3) begin
      errors++;
      $display("FAIL stall_cnt got %0d want 3", last_stall);
    end
`endif
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (n_shift != FILL_LEN) begin
      errors++;
      $display("FAIL fill_gap_count got %0d want %0d", n_shift, FILL_LEN);
    end
    cycle(1'b0, 1'b1, 1'b1);
    checks++;
    if (last_os !== 4'h0) begin
      errors++;
      $display("FAIL fill_gap_tap0 got %h want 0", last_os);
    end
    run_to_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fill_gap_timeout got no done want done within %0d cycles", BUDGET);
    end
  endtask

  task automatic test_out_ready_stall();
    bit ok;
    begin_frame();
    for (int i = 0; i < FILL_LEN; i++) cycle(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      checks++;
      if (last_os !== 4'hF) begin
        errors++;
        $display("FAIL stall_out_sel got %h want f", last_os);
      end
    end
    cycle(1'b0, 1'b0, 1'b1);
    checks++;
    if (last_os !== 4'h3) begin
      errors++;
      $display("FAIL stall_resume got %h want 3", last_os);
    end
    run_to_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_timeout got no done want done within %0d cycles", BUDGET);
    end
  endtask

  task automatic test_row_wrap();
    bit ok;
    int exp_w[$];
    bit bad;
    for (int w = 1; w <= NUM_WIN; w++) if (w % ROW_W == 0) exp_w.push_back(w);
    begin_frame();
    run_to_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL row_wrap_timeout got no done want done within %0d cycles", BUDGET);
    end
    bad = (wraps.size() != exp_w.size());
    if (!bad) for (int i = 0; i < exp_w.size(); i++) if (wraps[i] != exp_w[i]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL row_wrap_windows got %p want %p", wraps, exp_w);
    end
    cycle(1'b0, 1'b1, 1'b1);
    checks++;
    if ({n_done, last_bz} !== {32'd1, 1'b0}) begin
      errors++;
      $display("FAIL done_busy got done_pulses=%0d busy=%b want 1 0", n_done, last_bz);
    end
  endtask

  task automatic test_start_during_emit();
    bit ok;
    begin_frame();
    for (int i = 0; i < FILL_LEN; i++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    run_to_done(ok);
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if ({ok, n_done, n_shift, last_bz} !== {1'b1, 32'd1, 32'(FILL_LEN + NUM_WIN), 1'b0}) begin
      errors++;
      $display("FAIL start_ignored got ok=%b done=%0d shifts=%0d busy=%b want 1 1 %0d 0",
               ok, n_done, n_shift, last_bz, FILL_LEN + NUM_WIN);
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int f = 0; f < 3; f++) begin
      begin_frame();
      ok = 1'b0;
      for (int i = 0; i < BUDGET; i++) begin
        cycle($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
        if (last_dn) begin
          ok = 1'b1;
          break;
        end
      end
      cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if ({ok, n_done} !== {1'b1, 32'd1}) begin
        errors++;
        $display("FAIL random_frame got ok=%b done=%0d want 1 1", ok, n_done);
      end
      for (int i = 0; i < 40; i++) cycle(1'b0, $urandom_range(0, 1) == 1, 1'b1);
      apply_reset();
    end
  endtask

  initial begin
    test_reset();
    test_fill_emit();
    test_reset_mid_emit();
    test_fill_gap();
    test_out_ready_stall();
    test_row_wrap();
    test_start_during_emit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
